// File: rtl/seq_rda_div.sv
// Multi-cycle restoring divider with valid/ready handshakes and optional
// two's-complement operation; BITS_PER_CYCLE quotient bits are resolved per clock.
module seq_rda_div #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED_EN      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero,
  output logic             busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]    LAST    = CW'(N - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] ymag_q, ymag_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             out_valid_q, out_valid_d;
  logic             div_zero_q, div_zero_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             sgn_s, xs_s, ys_s;
  logic [WIDTH:0]   rem_w, diff_w;
  logic [WIDTH-1:0] quo_w;

  // Next-state, datapath step and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    ymag_d      = ymag_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    q_d         = q_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    div_zero_d  = div_zero_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    sgn_s       = (SIGNED_EN != 0) && is_signed;
    xs_s        = sgn_s && x[WIDTH-1];
    ys_s        = sgn_s && y[WIDTH-1];
    rem_w       = {1'b0, rem_q};
    quo_w       = quo_q;
    diff_w      = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (y == '0) begin
            // Zero divisor skips iteration; out_valid follows one cycle later in DONE
            q_d        = '1;
            r_d        = x;
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            quo_d      = xs_s ? negate(x) : x;
            ymag_d     = ys_s ? negate(y) : y;
            rem_d      = '0;
            qneg_d     = xs_s ^ ys_s;
            rneg_d     = xs_s;
            cnt_d      = '0;
            div_zero_d = 1'b0;
            state_d    = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        // Dividend bits shift out of quo into rem while quotient bits shift in
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
          rem_w  = {rem_w[WIDTH-1:0], quo_w[WIDTH-1]};
          quo_w  = {quo_w[WIDTH-2:0], 1'b0};
          diff_w = rem_w - {1'b0, ymag_q};
          if (diff_w[WIDTH]) begin
            rem_w = rem_w;
          end else begin
            rem_w    = diff_w;
            quo_w[0] = 1'b1;
          end
        end
        rem_d = rem_w[WIDTH-1:0];
        quo_d = quo_w;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        q_d         = qneg_q ? negate(quo_q) : quo_q;
        r_d         = rneg_q ? negate(rem_q) : rem_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      ymag_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      ymag_q      <= ymag_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      q_q         <= q_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign div_zero  = div_zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_rda_div.sv
// Directed bench for seq_rda_div at WIDTH=8, running BITS_PER_CYCLE=1 and 2
// instances side by side on shared request/response inputs.
module tb_seq_rda_div;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       is_signed;
  logic       out_ready;
  logic [7:0] x, y;

  logic       a_in_ready, a_out_valid, a_dz, a_busy;
  logic [7:0] a_q, a_r;
  logic       b_in_ready, b_out_valid, b_dz, b_busy;
  logic [7:0] b_q, b_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_rda_div #(.WIDTH(8), .BITS_PER_CYCLE(1), .SIGNED_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .x(x), .y(y), .is_signed(is_signed), .out_valid(a_out_valid),
    .out_ready(out_ready), .q(a_q), .r(a_r), .div_zero(a_dz), .busy(a_busy)
  );

  seq_rda_div #(.WIDTH(8), .BITS_PER_CYCLE(2), .SIGNED_EN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .x(x), .y(y), .is_signed(is_signed), .out_valid(b_out_valid),
    .out_ready(out_ready), .q(b_q), .r(b_r), .div_zero(b_dz), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] xv, input logic [7:0] yv, input logic sv,
                                output logic [7:0] eq, output logic [7:0] er, output logic edz);
    int xi, yi, qi, ri;
    if (yv == 8'd0) begin
      eq = 8'hFF; er = xv; edz = 1'b1;
    end else begin
      xi = sv ? int'($signed(xv)) : int'(xv);
      yi = sv ? int'($signed(yv)) : int'(yv);
      qi = xi / yi;
      ri = xi % yi;
      eq = qi[7:0]; er = ri[7:0]; edz = 1'b0;
    end
  endfunction

  task automatic run_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                        input logic sv, input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input int la, input int lb, input int hold);
    int ga, gb;
    @(negedge clk);
    x = xv; y = yv; is_signed = sv; in_valid = 1'b1;
    check({tag, "/ready"}, {a_in_ready, b_in_ready}, 2'b11);
    @(posedge clk);
    #1;
    in_valid = 1'b0; x = ~xv; y = ~yv; is_signed = ~sv;
    check({tag, "/busy"}, {a_busy, b_busy, a_in_ready, b_in_ready}, 4'b1100);
    ga = 0; gb = 0;
    for (int e = 1; e <= 40 && (ga == 0 || gb == 0); e++) begin
      @(posedge clk);
      #1;
      if (ga == 0 && a_out_valid) ga = e;
      if (gb == 0 && b_out_valid) gb = e;
    end
    check({tag, "/lat_a"}, ga, la);
    check({tag, "/lat_b"}, gb, lb);
    check({tag, "/a_res"}, {a_q, a_r, 7'd0, a_dz}, {eq, er, 7'd0, edz});
    check({tag, "/b_res"}, {b_q, b_r, 7'd0, b_dz}, {eq, er, 7'd0, edz});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold"}, {a_out_valid, a_in_ready, a_q, a_r, b_out_valid, b_in_ready, b_q, b_r},
            {1'b1, 1'b0, eq, er, 1'b1, 1'b0, eq, er});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/retire"}, {a_out_valid, a_in_ready, a_busy, b_out_valid, b_in_ready, b_busy},
          6'b010_010);
    check({tag, "/kept"}, {a_q, a_r}, {eq, er});
  endtask

  initial begin
    logic [7:0] rx, ry, mq, mr;
    logic       rs, mdz;
    rst_n = 1'b0; in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b0;
    x = 8'd0; y = 8'd0;
    #12;
    check("reset_a", {a_q, a_r, a_out_valid, a_dz, a_busy, a_in_ready}, {8'd0, 8'd0, 4'b0001});
    check("reset_b", {b_q, b_r, b_out_valid, b_dz, b_busy, b_in_ready}, {8'd0, 8'd0, 4'b0001});
    @(negedge clk);
    rst_n = 1'b1;

    run_op("unsigned_200_7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 9, 5, 0);
    run_op("signed_m7_2", 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 9, 5, 0);
    run_op("signed_7_m2", 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 9, 5, 0);
    run_op("div_zero", 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1, 1, 0);
    run_op("div_zero_s", 8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1, 1, 1, 0);
    run_op("ovf_signed", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9, 5, 0);
    run_op("ovf_unsigned", 8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 9, 5, 0);
    run_op("backpressure", 8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0, 9, 5, 5);

    // Out_ready while idle must not disturb anything
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_out_ready", {a_out_valid, a_in_ready, a_q, a_r}, {1'b0, 1'b1, 8'd11, 8'd1});

    // Reset in the middle of an iteration
    @(negedge clk);
    x = 8'd250; y = 8'd3; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midcalc_rst_a", {a_q, a_r, a_out_valid, a_dz, a_busy, a_in_ready}, {8'd0, 8'd0, 4'b0001});
    check("midcalc_rst_b", {b_q, b_r, b_out_valid, b_dz, b_busy, b_in_ready}, {8'd0, 8'd0, 4'b0001});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("after_rst", {a_out_valid, a_in_ready, a_busy, a_q, b_out_valid, b_in_ready, b_q},
          {3'b010, 8'd0, 2'b01, 8'd0});

    run_op("post_rst", 8'd250, 8'd3, 1'b0, 8'd83, 8'd1, 1'b0, 9, 5, 0);

    for (int k = 0; k < 40; k++) begin
      rx = 8'($urandom_range(0, 255));
      ry = (k % 10 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      model(rx, ry, rs, mq, mr, mdz);
      run_op("random", rx, ry, rs, mq, mr, mdz, (ry == 8'd0) ? 1 : 9, (ry == 8'd0) ? 1 : 5, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
